id_stage_reg: RTL
=================

ID_STAGE_REG -- requirements
Module: id_stage_reg

Interface
REQ-001 Parameter DATA_W, 32, datapath width of PC, operand and immediate fields.
REQ-002 Parameter REG_ADDR_W, 5, width of register-file address fields.
REQ-003 Parameter CNT_W, 16, width of the bubble performance counter.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 freeze  in  1  memory-side stall; register holds all contents.
REQ-007 flush  in  1  branch taken in EXE; squash the instruction being loaded.
REQ-008 hazard  in  1  data hazard from hazard unit; load a bubble instead of the ID instruction.
REQ-009 valid_in  in  1  ID holds a real instruction.
REQ-010 pc_in  in  DATA_W  PC+4 of the ID instruction.
REQ-011 alu_cmd_in  in  4  ALU command from the control unit; may be X for non-ALU ops.
REQ-012 mem_read_in, mem_write_in, wb_en_in, is_imm_in  in  1 each  control-unit flags.
REQ-013 branch_type_in  in  2  00 none, 01 BEZ, 10 BNE, 11 JMP.
REQ-014 val1_in, val2_in, st_val_in, imm_in  in  DATA_W each  operand values and sign-extended immediate.
REQ-015 dest_in, src1_in, src2_in  in  REG_ADDR_W each  register addresses.
REQ-016 *_out  out  same widths  registered copy of every *_in above, including valid_out.
REQ-017 bubble_cnt  out  CNT_W  saturating count of bubbles inserted.

Function
REQ-018 Per-cycle action priority SHALL be: freeze (hold) > flush (bubble) > hazard (bubble) > load.
REQ-019 Load SHALL copy all inputs to outputs at the next rising edge; latency one cycle.
REQ-020 Bubble SHALL clear valid_out, wb_en_out, mem_read_out, mem_write_out, is_imm_out, branch_type_out and alu_cmd_out to 0; data/address outputs SHALL also be cleared to 0.
REQ-021 Load with valid_in=0 SHALL be treated as a bubble for control fields but SHALL NOT increment bubble_cnt.
REQ-022 On load, alu_cmd_out SHALL be 0 whenever wb_en_in=0 and mem_write_in=0, so no X propagates downstream.
REQ-023 Hold SHALL retain every output, including bubble_cnt, regardless of flush or hazard.
REQ-024 bubble_cnt SHALL increment by 1 on each bubble caused by flush or hazard, and SHALL saturate at 2^CNT_W-1 without wrap.
REQ-025 flush and hazard in the same cycle SHALL produce one bubble and one count increment.
REQ-026 The block SHALL contain no combinational path from any input to any output.

Reset
REQ-027 rst=1 SHALL immediately and asynchronously force all outputs and bubble_cnt to 0, overriding freeze.
REQ-028 Reset asserted during a freeze or bubble SHALL discard it; the first edge after deassert SHALL follow REQ-018 normally.

Structure
REQ-029 A shared package SHALL hold DATA_W, REG_ADDR_W, the branch_type encodings and the ALU command width/encodings, for use also by the control unit and EXE stage.
REQ-030 The saturating counter SHALL be a sub-module named sat_counter (ports clk, rst, inc, cnt; parameter CNT_W).

Verification
REQ-031 Scenario: reset, then load pc_in=0x10, alu_cmd_in=4'b0010, wb_en_in=1, dest_in=5, valid_in=1 -> one edge later outputs match; bubble_cnt=0.
REQ-032 Scenario: freeze=1 for 3 cycles with changing inputs and flush=1 -> outputs unchanged, bubble_cnt unchanged; after freeze drops, flush bubble taken -> valid_out=0, bubble_cnt=1.
REQ-033 Scenario: hazard=1 with mem_write_in=1 -> mem_write_out=0, valid_out=0, bubble_cnt+1; hazard=0 next cycle -> instruction loaded.
REQ-034 Scenario: flush=1 and hazard=1 together -> single bubble, bubble_cnt increments by exactly 1.
REQ-035 Scenario: CNT_W=4, 20 consecutive hazard cycles -> bubble_cnt stops at 15.
REQ-036 Scenario: alu_cmd_in=4'bxxxx, wb_en_in=0, mem_write_in=0, branch_type_in=01 -> alu_cmd_out=0, branch_type_out=01; rst pulsed mid-cycle -> all outputs 0 before next edge.

Source files
------------

// File: rtl/id_stage_reg_pkg.sv
// Shared ID-stage definitions: datapath widths, branch and ALU command encodings.
package id_stage_reg_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned ALU_CMD_W  = 4;
  localparam int unsigned BR_TYPE_W  = 2;

  typedef enum logic [BR_TYPE_W-1:0] {
    BR_NONE = 2'b00,
    BR_BEZ  = 2'b01,
    BR_BNE  = 2'b10,
    BR_JMP  = 2'b11
  } branch_type_e;

  typedef enum logic [ALU_CMD_W-1:0] {
    ALU_NOP = 4'b0000,
    ALU_MOV = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0011,
    ALU_AND = 4'b0100,
    ALU_OR  = 4'b0101,
    ALU_XOR = 4'b0110,
    ALU_SHL = 4'b0111,
    ALU_SHR = 4'b1000
  } alu_cmd_e;

  // Per-cycle action of the pipeline register.
  typedef enum logic [1:0] {
    ACT_LOAD   = 2'd0,
    ACT_BUBBLE = 2'd1,
    ACT_HOLD   = 2'd2
  } id_action_e;

  // The ALU command only carries meaning for ops that write back or store.
  function automatic logic alu_cmd_used(input logic wb_en, input logic mem_write);
    return wb_en | mem_write;
  endfunction

endpackage

// File: rtl/id_stage_reg_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: advance unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  // Count register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/id_stage_reg.sv
// ID/EXE pipeline register with freeze/flush/hazard control and bubble counter.
module id_stage_reg
  import id_stage_reg_pkg::*;
#(
  parameter int unsigned DATA_W     = id_stage_reg_pkg::DATA_W,
  parameter int unsigned REG_ADDR_W = id_stage_reg_pkg::REG_ADDR_W,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  flush,
  input  logic                  hazard,
  input  logic                  valid_in,
  input  logic [DATA_W-1:0]     pc_in,
  input  logic [ALU_CMD_W-1:0]  alu_cmd_in,
  input  logic                  mem_read_in,
  input  logic                  mem_write_in,
  input  logic                  wb_en_in,
  input  logic                  is_imm_in,
  input  logic [BR_TYPE_W-1:0]  branch_type_in,
  input  logic [DATA_W-1:0]     val1_in,
  input  logic [DATA_W-1:0]     val2_in,
  input  logic [DATA_W-1:0]     st_val_in,
  input  logic [DATA_W-1:0]     imm_in,
  input  logic [REG_ADDR_W-1:0] dest_in,
  input  logic [REG_ADDR_W-1:0] src1_in,
  input  logic [REG_ADDR_W-1:0] src2_in,
  output logic                  valid_out,
  output logic [DATA_W-1:0]     pc_out,
  output logic [ALU_CMD_W-1:0]  alu_cmd_out,
  output logic                  mem_read_out,
  output logic                  mem_write_out,
  output logic                  wb_en_out,
  output logic                  is_imm_out,
  output logic [BR_TYPE_W-1:0]  branch_type_out,
  output logic [DATA_W-1:0]     val1_out,
  output logic [DATA_W-1:0]     val2_out,
  output logic [DATA_W-1:0]     st_val_out,
  output logic [DATA_W-1:0]     imm_out,
  output logic [REG_ADDR_W-1:0] dest_out,
  output logic [REG_ADDR_W-1:0] src1_out,
  output logic [REG_ADDR_W-1:0] src2_out,
  output logic [CNT_W-1:0]      bubble_cnt
);

  id_action_e act;

  logic                  valid_q,    valid_d;
  logic [DATA_W-1:0]     pc_q,       pc_d;
  logic [ALU_CMD_W-1:0]  alu_cmd_q,  alu_cmd_d;
  logic                  mem_read_q, mem_read_d;
  logic                  mem_write_q, mem_write_d;
  logic                  wb_en_q,    wb_en_d;
  logic                  is_imm_q,   is_imm_d;
  logic [BR_TYPE_W-1:0]  br_type_q,  br_type_d;
  logic [DATA_W-1:0]     val1_q,     val1_d;
  logic [DATA_W-1:0]     val2_q,     val2_d;
  logic [DATA_W-1:0]     st_val_q,   st_val_d;
  logic [DATA_W-1:0]     imm_q,      imm_d;
  logic [REG_ADDR_W-1:0] dest_q,     dest_d;
  logic [REG_ADDR_W-1:0] src1_q,     src1_d;
  logic [REG_ADDR_W-1:0] src2_q,     src2_d;

  // Action select: freeze beats flush/hazard, which beat a normal load.
  always_comb begin
    act = ACT_LOAD;
    if (freeze)                act = ACT_HOLD;
    else if (flush || hazard)  act = ACT_BUBBLE;
  end

  // Next-state for every field; default holds current contents.
  always_comb begin
    valid_d     = valid_q;
    pc_d        = pc_q;
    alu_cmd_d   = alu_cmd_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    wb_en_d     = wb_en_q;
    is_imm_d    = is_imm_q;
    br_type_d   = br_type_q;
    val1_d      = val1_q;
    val2_d      = val2_q;
    st_val_d    = st_val_q;
    imm_d       = imm_q;
    dest_d      = dest_q;
    src1_d      = src1_q;
    src2_d      = src2_q;
    case (act)
      ACT_BUBBLE: begin
        valid_d     = 1'b0;
        pc_d        = '0;
        alu_cmd_d   = '0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        wb_en_d     = 1'b0;
        is_imm_d    = 1'b0;
        br_type_d   = '0;
        val1_d      = '0;
        val2_d      = '0;
        st_val_d    = '0;
        imm_d       = '0;
        dest_d      = '0;
        src1_d      = '0;
        src2_d      = '0;
      end
      ACT_LOAD: begin
        // An empty slot loads its data fields but carries no control, so it
        // behaves as a bubble downstream without counting as one.
        valid_d     = valid_in;
        pc_d        = pc_in;
        mem_read_d  = valid_in & mem_read_in;
        mem_write_d = valid_in & mem_write_in;
        wb_en_d     = valid_in & wb_en_in;
        is_imm_d    = valid_in & is_imm_in;
        br_type_d   = valid_in ? branch_type_in : '0;
        alu_cmd_d   = (valid_in && alu_cmd_used(wb_en_in, mem_write_in)) ? alu_cmd_in : '0;
        val1_d      = val1_in;
        val2_d      = val2_in;
        st_val_d    = st_val_in;
        imm_d       = imm_in;
        dest_d      = dest_in;
        src1_d      = src1_in;
        src2_d      = src2_in;
      end
      default: ;
    endcase
  end

  // Pipeline register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      alu_cmd_q   <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      wb_en_q     <= 1'b0;
      is_imm_q    <= 1'b0;
      br_type_q   <= '0;
      val1_q      <= '0;
      val2_q      <= '0;
      st_val_q    <= '0;
      imm_q       <= '0;
      dest_q      <= '0;
      src1_q      <= '0;
      src2_q      <= '0;
    end else begin
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      alu_cmd_q   <= alu_cmd_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      wb_en_q     <= wb_en_d;
      is_imm_q    <= is_imm_d;
      br_type_q   <= br_type_d;
      val1_q      <= val1_d;
      val2_q      <= val2_d;
      st_val_q    <= st_val_d;
      imm_q       <= imm_d;
      dest_q      <= dest_d;
      src1_q      <= src1_d;
      src2_q      <= src2_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk (clk),
    .rst (rst),
    .inc (act == ACT_BUBBLE),
    .cnt (bubble_cnt)
  );

  assign valid_out       = valid_q;
  assign pc_out          = pc_q;
  assign alu_cmd_out     = alu_cmd_q;
  assign mem_read_out    = mem_read_q;
  assign mem_write_out   = mem_write_q;
  assign wb_en_out       = wb_en_q;
  assign is_imm_out      = is_imm_q;
  assign branch_type_out = br_type_q;
  assign val1_out        = val1_q;
  assign val2_out        = val2_q;
  assign st_val_out      = st_val_q;
  assign imm_out         = imm_q;
  assign dest_out        = dest_q;
  assign src1_out        = src1_q;
  assign src2_out        = src2_q;

endmodule
